// File: rtl/l2_mem_pkg.sv
// Shared types for the L2-to-pmem scheduler: line type, grant state encoding
// and line-address helpers.
package l2_mem_pkg;
    localparam int LINE_OFFSET_BITS = 5;

    typedef logic [255:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        DEM,
        WB,
        PF
    } sched_state_t;

    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
        return a[31:LINE_OFFSET_BITS] == b[31:LINE_OFFSET_BITS];
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return {a[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    endfunction
endpackage

// File: rtl/l2_mem_scheduler_if.sv
// Request, completion and pmem signals of the scheduler. The master side is the
// requester/memory environment; the slave side is the scheduler itself.
interface l2_mem_scheduler_if;
    import l2_mem_pkg::*;

    logic        dem_read;
    logic [31:0] dem_address;
    line_t       dem_rdata;
    logic        dem_resp;

    logic        wb_write;
    logic [31:0] wb_address;
    line_t       wb_wdata;
    logic        wb_resp;

    logic        pf_read;
    logic [31:0] pf_address;
    line_t       pf_rdata;
    logic        pf_resp;

    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    line_t       pmem_wdata;
    line_t       pmem_rdata;
    logic        pmem_resp;

    modport master (
        output dem_read, dem_address, wb_write, wb_address, wb_wdata,
               pf_read, pf_address, pmem_rdata, pmem_resp,
        input  dem_rdata, dem_resp, wb_resp, pf_rdata, pf_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        input  dem_read, dem_address, wb_write, wb_address, wb_wdata,
               pf_read, pf_address, pmem_rdata, pmem_resp,
        output dem_rdata, dem_resp, wb_resp, pf_rdata, pf_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/l2_sched_arbiter.sv
// Purpose: picks the next pmem grant from the pending requests while the scheduler is idle.
// Latency: purely combinational.
// Backpressure: none of its own; a losing requester simply keeps its request held.
module l2_sched_arbiter
    import l2_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             dem_read,
    input  logic             wb_write,
    input  logic             pf_read,
    input  logic             dem_wb_hit,
    input  logic [CNT_W-1:0] starve_cnt,
    output sched_state_t     grant
);
    always_comb begin
        grant = IDLE;
        if (wb_write && ((dem_read && dem_wb_hit) || starve_cnt == CNT_W'(STARVE_LIMIT)))
            grant = WB;
        else if (dem_read)
            grant = DEM;
        // wb outranks pf, so a pf read of a line still waiting to be written back never wins
        else if (wb_write)
            grant = WB;
        else if (pf_read)
            grant = PF;
    end
endmodule

// File: rtl/l2_mem_scheduler.sv
// Purpose: shares the single 256-bit pmem port between demand, write-back and prefetch requesters.
// Latency: pmem command 1 cycle after a request is seen idle; requester resp in the pmem_resp cycle.
// Backpressure: requesters hold their request until resp; one non-preemptive pmem transaction at a time.
module l2_mem_scheduler
    import l2_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    l2_mem_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    sched_state_t     state;
    sched_state_t     grant;
    logic [CNT_W-1:0] starve_cnt;
    logic [31:0]      grant_addr;
    logic             dem_wb_hit;

    assign dem_wb_hit = same_line(bus.dem_address, bus.wb_address);

    l2_sched_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CNT_W       (CNT_W)
    ) u_arb (
        .dem_read  (bus.dem_read),
        .wb_write  (bus.wb_write),
        .pf_read   (bus.pf_read),
        .dem_wb_hit(dem_wb_hit),
        .starve_cnt(starve_cnt),
        .grant     (grant)
    );

    always_comb begin
        grant_addr = '0;
        case (grant)
            DEM:     grant_addr = line_base(bus.dem_address);
            WB:      grant_addr = line_base(bus.wb_address);
            PF:      grant_addr = line_base(bus.pf_address);
            default: grant_addr = '0;
        endcase
    end

    // Read data is a straight pass-through; only the per-requester resp qualifies it.
    assign bus.dem_rdata = bus.pmem_rdata;
    assign bus.pf_rdata  = bus.pmem_rdata;
    assign bus.dem_resp  = !reset && (state == DEM) && bus.pmem_resp;
    assign bus.wb_resp   = !reset && (state == WB)  && bus.pmem_resp;
    assign bus.pf_resp   = !reset && (state == PF)  && bus.pmem_resp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            starve_cnt       <= '0;
            bus.pmem_read    <= 1'b0;
            bus.pmem_write   <= 1'b0;
            bus.pmem_address <= '0;
            bus.pmem_wdata   <= '0;
        end else begin
            if (!bus.wb_write)
                starve_cnt <= '0;
            else if (state == IDLE && grant == WB)
                starve_cnt <= '0;
            else if (state == IDLE && grant == DEM && starve_cnt != CNT_W'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;

            case (state)
                IDLE: begin
                    state            <= grant;
                    bus.pmem_read    <= (grant == DEM) || (grant == PF);
                    bus.pmem_write   <= (grant == WB);
                    bus.pmem_address <= grant_addr;
                    bus.pmem_wdata   <= (grant == WB) ? bus.wb_wdata : '0;
                end
                default: begin
                    if (bus.pmem_resp) begin
                        state            <= IDLE;
                        bus.pmem_read    <= 1'b0;
                        bus.pmem_write   <= 1'b0;
                        bus.pmem_address <= '0;
                        bus.pmem_wdata   <= '0;
                    end
                end
            endcase
        end
    end
endmodule
